// File: rtl/rca_pipe_arbiter_pkg.sv
// Shared defaults and requester identifier type for the pipelined-adder arbiter.
// Imported by the arbiter top and by the adder pipeline.
package rca_pipe_arbiter_pkg;

  localparam int unsigned DefWidth  = 4;
  localparam int unsigned DefStages = 4;
  localparam int unsigned DefMaxOut = 2;

  typedef enum logic {
    Req0 = 1'b0,
    Req1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/add_pipe.sv
// Ripple-carry adder split into STAGES bit slices, one slice resolved per register rank.
// A reset valid/tag lane runs alongside; the operand, sum and carry registers carry no reset.
module add_pipe
  import rca_pipe_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  req_id_e          tag_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  output req_id_e          tag_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned SliceW = (WIDTH + STAGES - 1) / STAGES;

  // Rank 0 captures the issued operands; rank s+1 holds the sum with slice s resolved.
  logic [STAGES:0]  valid_d, valid_q;
  req_id_e          tag_d   [STAGES+1];
  req_id_e          tag_q   [STAGES+1];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES+1];
  logic [WIDTH-1:0] sum_q   [STAGES+1];
  logic             carry_d [STAGES+1];
  logic             carry_q [STAGES+1];

  // Resolves only the bits belonging to one slice; other sum bits pass through.
  function automatic logic [WIDTH:0] slice_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] sum_in,
                                               input logic             cin,
                                               input int unsigned      stage);
    logic [WIDTH-1:0] s;
    logic             c;
    s = sum_in;
    c = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i / SliceW == stage) begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return {c, s};
  endfunction

  always_comb begin
    valid_d    = {valid_q[STAGES-1:0], valid_i};
    tag_d[0]   = tag_i;
    a_d[0]     = a_i;
    b_d[0]     = b_i;
    sum_d[0]   = '0;
    carry_d[0] = cin_i;
    for (int unsigned s = 0; s < STAGES; s++) begin
      tag_d[s+1] = tag_q[s];
      {carry_d[s+1], sum_d[s+1]} = slice_add(a_q[s], b_q[s], sum_q[s], carry_q[s], s);
    end
    for (int unsigned s = 1; s < STAGES; s++) begin
      a_d[s] = a_q[s-1];
      b_d[s] = b_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      tag_q   <= '{default: Req0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk_i) begin
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
    carry_q <= carry_d;
  end

  assign valid_o = valid_q[STAGES];
  assign tag_o   = tag_q[STAGES];
  assign sum_o   = sum_q[STAGES];
  assign cout_o  = carry_q[STAGES];

endmodule

// File: rtl/rca_pipe_arbiter.sv
// Two-requester round-robin front end for a shared pipelined adder, with per-requester
// in-flight limits and tagged one-cycle response pulses.
module rca_pipe_arbiter
  import rca_pipe_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned STAGES  = DefStages,
  parameter int unsigned MAX_OUT = DefMaxOut
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic             req_cin_0,
  input  logic             req_cin_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [1:0]       outstanding_0,
  output logic [1:0]       outstanding_1
);

  localparam logic [1:0] MaxCnt = 2'(MAX_OUT);

  logic             elig_0, elig_1;
  logic             grant_0, grant_1;
  logic             issue;
  req_id_e          issue_tag;
  logic [WIDTH-1:0] issue_a, issue_b;
  logic             issue_cin;
  req_id_e          ptr_d, ptr_q;
  logic [1:0]       cnt_0_d, cnt_0_q, cnt_1_d, cnt_1_q;
  logic             pipe_valid;
  req_id_e          pipe_tag;
  logic [WIDTH-1:0] pipe_sum;
  logic             pipe_cout;

  function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic inc,
                                          input logic dec);
    logic [1:0] n;
    unique case ({inc, dec})
      2'b10:   n = cnt + 2'd1;
      2'b01:   n = cnt - 2'd1;
      default: n = cnt;
    endcase
    return n;
  endfunction

  // Grants are gated by rst_n so ready reads 0 while reset is held.
  always_comb begin
    elig_0  = req_valid_0 && (cnt_0_q < MaxCnt);
    elig_1  = req_valid_1 && (cnt_1_q < MaxCnt);
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (rst_n) begin
      unique case ({elig_1, elig_0})
        2'b01: grant_0 = 1'b1;
        2'b10: grant_1 = 1'b1;
        2'b11: begin
          if (ptr_q == Req0) grant_0 = 1'b1;
          else               grant_1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    issue     = grant_0 | grant_1;
    issue_tag = grant_1 ? Req1 : Req0;
    issue_a   = grant_1 ? req_a_1 : req_a_0;
    issue_b   = grant_1 ? req_b_1 : req_b_0;
    issue_cin = grant_1 ? req_cin_1 : req_cin_0;
    ptr_d     = ptr_q;
    if (issue) ptr_d = grant_0 ? Req1 : Req0;
  end

  always_comb begin
    rsp_valid_0 = pipe_valid && (pipe_tag == Req0);
    rsp_valid_1 = pipe_valid && (pipe_tag == Req1);
    rsp_sum     = pipe_valid ? pipe_sum : '0;
    rsp_cout    = pipe_valid & pipe_cout;
    cnt_0_d     = next_cnt(cnt_0_q, grant_0, rsp_valid_0);
    cnt_1_d     = next_cnt(cnt_1_q, grant_1, rsp_valid_1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= Req0;
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  add_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_add_pipe (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .valid_i (issue),
    .tag_i   (issue_tag),
    .a_i     (issue_a),
    .b_i     (issue_b),
    .cin_i   (issue_cin),
    .valid_o (pipe_valid),
    .tag_o   (pipe_tag),
    .sum_o   (pipe_sum),
    .cout_o  (pipe_cout)
  );

  assign req_ready_0   = grant_0;
  assign req_ready_1   = grant_1;
  assign outstanding_0 = cnt_0_q;
  assign outstanding_1 = cnt_1_q;

endmodule

// File: tb/tb_rca_pipe_arbiter.sv
// Scenario tasks for rca_pipe_arbiter checked against a queue-based transaction model.
module tb_rca_pipe_arbiter;

  localparam int W  = 4;
  localparam int ST = 4;
  localparam int MO = 2;
  localparam int OW = W + 9;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid_0, req_valid_1;
  logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic         req_cin_0, req_cin_1;
  logic         req_ready_0, req_ready_1;
  logic         rsp_valid_0, rsp_valid_1;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic [1:0]   outstanding_0, outstanding_1;

  always #5 clock = ~clock;

  rca_pipe_arbiter #(
    .WIDTH   (W),
    .STAGES  (ST),
    .MAX_OUT (MO)
  ) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .req_valid_0   (req_valid_0),
    .req_valid_1   (req_valid_1),
    .req_a_0       (req_a_0),
    .req_b_0       (req_b_0),
    .req_a_1       (req_a_1),
    .req_b_1       (req_b_1),
    .req_cin_0     (req_cin_0),
    .req_cin_1     (req_cin_1),
    .req_ready_0   (req_ready_0),
    .req_ready_1   (req_ready_1),
    .rsp_valid_0   (rsp_valid_0),
    .rsp_valid_1   (rsp_valid_1),
    .rsp_sum       (rsp_sum),
    .rsp_cout      (rsp_cout),
    .outstanding_0 (outstanding_0),
    .outstanding_1 (outstanding_1)
  );

  // Model: pending results with the cycle they are due, plain counters and a turn pointer.
  typedef struct {
    int due;
    int tag;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt[2];
  int   m_ptr;
  int   cyc;
  int   errors;
  int   checks;

  function automatic int m_winner();
    bit e0, e1;
    if (!rst_n) return -1;
    e0 = req_valid_0 && (m_cnt[0] < MO);
    e1 = req_valid_1 && (m_cnt[1] < MO);
    if (e0 && e1) return m_ptr;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic int m_rsp_tag();
    if (exp_q.size() > 0 && exp_q[0].due == cyc) return exp_q[0].tag;
    return -1;
  endfunction

  function automatic logic [OW-1:0] model_outputs();
    int         w, t, val;
    logic [W:0] vv;
    logic [1:0] c0, c1;
    w   = m_winner();
    t   = m_rsp_tag();
    val = (t >= 0) ? exp_q[0].val : 0;
    vv  = val[W:0];
    c0  = m_cnt[0][1:0];
    c1  = m_cnt[1][1:0];
    return {w == 1, w == 0, t == 1, t == 0, vv, c1, c0};
  endfunction

  function automatic logic [OW-1:0] dut_outputs();
    return {req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0, rsp_cout, rsp_sum,
            outstanding_1, outstanding_0};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_ptr    = 0;
  endtask

  task automatic drive_idle();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    req_a_0 = '0; req_b_0 = '0; req_cin_0 = 1'b0;
    req_a_1 = '0; req_b_1 = '0; req_cin_1 = 1'b0;
  endtask

  task automatic rand_ops();
    req_a_0   = W'($urandom);
    req_b_0   = W'($urandom);
    req_cin_0 = 1'($urandom);
    req_a_1   = W'($urandom);
    req_b_1   = W'($urandom);
    req_cin_1 = 1'($urandom);
  endtask

  // Advance one clock edge and apply the transaction rules to the model; returns at negedge.
  task automatic tick();
    int   w, t, v;
    exp_t e;
    w = m_winner();
    t = m_rsp_tag();
    if (w == 0)      v = int'(req_a_0) + int'(req_b_0) + int'(req_cin_0);
    else if (w == 1) v = int'(req_a_1) + int'(req_b_1) + int'(req_cin_1);
    else             v = 0;
    @(posedge clock);
    cyc++;
    if (rst_n) begin
      if (t >= 0) begin
        m_cnt[t]--;
        void'(exp_q.pop_front());
      end
      if (w >= 0) begin
        m_cnt[w]++;
        e.due = cyc + ST;
        e.tag = w;
        e.val = v;
        exp_q.push_back(e);
        m_ptr = 1 - w;
      end
    end
    @(negedge clock);
  endtask

  task automatic start_clean();
    rst_n = 1'b0;
    model_reset();
    drive_idle();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp;
    rst_n = 1'b0;
    model_reset();
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    rand_ops();
    #1;
    checks++;
    if (dut_outputs() !== '0)
      $display("FAIL reset_outputs: got %h expected 0", dut_outputs());
    tick();
    tick();
    checks++;
    if (dut_outputs() !== '0)
      $display("FAIL reset_hold: got %h expected 0", dut_outputs());
    rst_n = 1'b1;
    #1;
    exp = model_outputs();
    checks++;
    if (dut_outputs() !== exp) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", dut_outputs(), exp);
    end
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++;
      $display("FAIL first_issue_ready: got %b%b expected 01", req_ready_1, req_ready_0);
    end
    tick();
    #1;
    checks++;
    if (outstanding_0 !== 2'd1) begin
      errors++;
      $display("FAIL first_issue_count: got %0d expected 1", outstanding_0);
    end
    drive_idle();
  endtask

  task automatic test_single();
    int n;
    start_clean();
    req_valid_0 = 1'b1;
    req_a_0 = W'(4); req_b_0 = W'(2); req_cin_0 = 1'b0;
    #1;
    checks++;
    if (req_ready_0 !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b expected 1", req_ready_0);
    end
    tick();
    drive_idle();
    #1;
    n = 0;
    while (n < 10 && rsp_valid_0 !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (n != ST) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles expected %0d", n, ST);
    end
    checks++;
    if ({rsp_cout, rsp_sum} !== (W+1)'(6) || rsp_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got cout=%b sum=%0d v1=%b expected cout=0 sum=6 v1=0",
               rsp_cout, rsp_sum, rsp_valid_1);
    end
    tick();
    checks++;
    if (rsp_valid_0 !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: got %b expected 0", rsp_valid_0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_clean();
    req_valid_1 = 1'b1;
    req_a_1 = W'(10); req_b_1 = W'(3); req_cin_1 = 1'b1;
    #1;
    checks++;
    if (req_ready_1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_first: got %b expected 1", req_ready_1);
    end
    tick();
    req_a_1 = W'(15); req_b_1 = W'(1); req_cin_1 = 1'b0;
    #1;
    checks++;
    if (req_ready_1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_second: got %b expected 1", req_ready_1);
    end
    tick();
    drive_idle();
    #1;
    n = 0;
    while (n < 10 && rsp_valid_1 !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (n != ST - 1 || {rsp_cout, rsp_sum} !== (W+1)'(14)) begin
      errors++;
      $display("FAIL b2b_first_rsp: got wait=%0d cout=%b sum=%0d expected wait=%0d cout=0 sum=14",
               n, rsp_cout, rsp_sum, ST - 1);
    end
    tick();
    checks++;
    if (rsp_valid_1 !== 1'b1 || {rsp_cout, rsp_sum} !== (W+1)'(16)) begin
      errors++;
      $display("FAIL b2b_second_rsp: got v=%b cout=%b sum=%0d expected v=1 cout=1 sum=0",
               rsp_valid_1, rsp_cout, rsp_sum);
    end
    tick();
    checks++;
    if (rsp_valid_1 !== 1'b0 || rsp_sum !== '0 || rsp_cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_zero: got v=%b cout=%b sum=%0d expected all 0",
               rsp_valid_1, rsp_cout, rsp_sum);
    end
  endtask

  task automatic test_alternate();
    int            grants[$];
    int            tags[$];
    logic [OW-1:0] exp;
    start_clean();
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rand_ops();
      #1;
      exp = model_outputs();
      checks++;
      if (dut_outputs() !== exp) begin
        errors++;
        $display("FAIL alt_cycle: got %h expected %h at cycle %0d", dut_outputs(), exp, cyc);
      end
      checks++;
      if (outstanding_0 > 2'(MO) || outstanding_1 > 2'(MO)) begin
        errors++;
        $display("FAIL alt_max_out: got %0d/%0d expected <= %0d", outstanding_0, outstanding_1, MO);
      end
      if (req_ready_0) grants.push_back(0);
      if (req_ready_1) grants.push_back(1);
      if (rsp_valid_0) tags.push_back(0);
      if (rsp_valid_1) tags.push_back(1);
      tick();
    end
    drive_idle();
    checks++;
    if (grants.size() < 10 || tags.size() < 8) begin
      errors++;
      $display("FAIL alt_volume: got %0d grants %0d responses expected >=10 and >=8",
               grants.size(), tags.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] != i % 2) begin
        errors++;
        $display("FAIL alt_grant: got %0d expected %0d at grant %0d", grants[i], i % 2, i);
      end
    end
    for (int i = 0; i < tags.size(); i++) begin
      checks++;
      if (tags[i] != i % 2) begin
        errors++;
        $display("FAIL alt_rsp_tag: got %0d expected %0d at response %0d", tags[i], i % 2, i);
      end
    end
  endtask

  task automatic test_hold();
    bit            found;
    logic [OW-1:0] exp;
    start_clean();
    req_valid_0 = 1'b1;
    rand_ops();
    #1;
    tick();
    rand_ops();
    #1;
    tick();
    #1;
    checks++;
    if (outstanding_0 !== 2'd2 || req_ready_0 !== 1'b0) begin
      errors++;
      $display("FAIL hold_full: got count=%0d ready=%b expected count=2 ready=0",
               outstanding_0, req_ready_0);
    end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      #1;
      exp = model_outputs();
      checks++;
      if (dut_outputs() !== exp) begin
        errors++;
        $display("FAIL hold_cycle: got %h expected %h at cycle %0d", dut_outputs(), exp, cyc);
      end
      if (!found && rsp_valid_0 && req_ready_0) begin
        found = 1'b1;
        tick();
        #1;
        checks++;
        if (outstanding_0 !== 2'd1) begin
          errors++;
          $display("FAIL hold_same_edge: got %0d expected 1", outstanding_0);
        end
      end else begin
        tick();
      end
    end
    drive_idle();
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hold_found: got no issue/response overlap expected one");
    end
  endtask

  task automatic test_reset_flush();
    start_clean();
    req_valid_0 = 1'b1;
    rand_ops();
    #1;
    tick();
    drive_idle();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_outputs() !== '0) begin
      errors++;
      $display("FAIL flush_outputs: got %h expected 0", dut_outputs());
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < ST + 4; i++) begin
      #1;
      checks++;
      if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0 || outstanding_0 !== 2'd0 ||
          outstanding_1 !== 2'd0) begin
        errors++;
        $display("FAIL flush_no_rsp: got v=%b%b cnt=%0d/%0d expected all 0",
                 rsp_valid_1, rsp_valid_0, outstanding_1, outstanding_0);
      end
      tick();
    end
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ptr: got ready=%b%b expected 01", req_ready_1, req_ready_0);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [OW-1:0] exp;
    start_clean();
    for (int i = 0; i < 400; i++) begin
      req_valid_0 = ($urandom_range(0, 3) != 0);
      req_valid_1 = ($urandom_range(0, 3) != 0);
      rand_ops();
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
      end
      #1;
      exp = model_outputs();
      checks++;
      if (dut_outputs() !== exp) begin
        errors++;
        $display("FAIL random_cycle: got %h expected %h at cycle %0d", dut_outputs(), exp, cyc);
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    drive_idle();
    model_reset();
    @(negedge clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_alternate();
    test_hold();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
